// File: rtl/bcd_display_pkg.sv
`default_nettype none
// ============================================================================
// bcd_display_pkg : FSM states, segment constants and digit lookup shared by
//                   bcd_display_driver and bcd_seg7_enc.       Rev 1.0
// ============================================================================
package bcd_display_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;

  // Active-low, bit0 = a ... bit6 = g; non-decimal codes render blank.
  function automatic logic [6:0] seg7_lut(input logic [3:0] digit);
    case (digit)
      4'd0:    seg7_lut = 7'b1000000;
      4'd1:    seg7_lut = 7'b1111001;
      4'd2:    seg7_lut = 7'b0100100;
      4'd3:    seg7_lut = 7'b0110000;
      4'd4:    seg7_lut = 7'b0011001;
      4'd5:    seg7_lut = 7'b0010010;
      4'd6:    seg7_lut = 7'b0000010;
      4'd7:    seg7_lut = 7'b1111000;
      4'd8:    seg7_lut = 7'b0000000;
      4'd9:    seg7_lut = 7'b0010000;
      default: seg7_lut = SEG_BLANK;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_seg7_enc.sv
`default_nettype none
// ============================================================================
// bcd_seg7_enc : one BCD digit plus blank flag to an active-low 7-segment
//                pattern.                                      Rev 1.0
// ============================================================================
module bcd_seg7_enc
  import bcd_display_pkg::*;
(
  input  logic [3:0] digit_i,
  input  logic       blank_i,
  output logic [6:0] seg_o
);

  assign seg_o = blank_i ? SEG_BLANK : seg7_lut(digit_i);

endmodule
`default_nettype wire

// File: rtl/bcd_display_driver.sv
`default_nettype none
// ============================================================================
// bcd_display_driver : sequential double-dabble binary-to-BCD converter
//   driving DIGITS active-low 7-segment displays, with overflow dashes.
//   Optional macro LEADING_ZERO_BLANK_EN blanks leading zero digits.  Rev 1.0
// ============================================================================
module bcd_display_driver
  import bcd_display_pkg::*;
#(
  parameter int WIDTH        = 32,
  parameter int DIGITS       = 6,
  parameter int REFRESH_BITS = 25
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      value,
  input  logic                  update,
  output logic [7*DIGITS-1:0]   hex,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam int BCD_W = 4 * DIGITS;

  state_e                  state_q, state_d;
  logic [REFRESH_BITS-1:0] refresh_q;
  logic [WIDTH-1:0]        shift_q, shift_d;
  logic [BCD_W-1:0]        bcd_q, bcd_d, bcd_adj;
  logic                    carry_q, carry_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [7*DIGITS-1:0]     hex_q, hex_d, seg_all;
  logic                    ovf_q, ovf_d;
  logic                    done_q, done_d;
  logic [DIGITS-1:0]       blank;
  logic                    tick;

  assign tick = (refresh_q == '0);

  always_comb begin
    bcd_adj = bcd_q;
    for (int k = 0; k < DIGITS; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) begin
        bcd_adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
      end
    end
  end

`ifdef LEADING_ZERO_BLANK_EN
  logic seen_nz;
  // Digit 0 is never blanked so that zero still shows a single "0".
  always_comb begin
    blank   = '0;
    seen_nz = 1'b0;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      seen_nz  = seen_nz | (bcd_q[4*k +: 4] != 4'd0);
      blank[k] = ~seen_nz;
    end
  end
`else
  assign blank = '0;
`endif

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    bcd_seg7_enc u_enc (
      .digit_i (bcd_q[4*i +: 4]),
      .blank_i (blank[i]),
      .seg_o   (seg_all[7*i +: 7])
    );
  end

  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    bcd_d   = bcd_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    hex_d   = hex_q;
    ovf_d   = ovf_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (tick || update) begin
          shift_d = value;
          bcd_d   = '0;
          carry_d = 1'b0;
          cnt_d   = CNT_W'(WIDTH);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        // Any bit pushed out of the top digit means the value needs more digits.
        bcd_d   = {bcd_adj[BCD_W-2:0], shift_q[WIDTH-1]};
        shift_d = {shift_q[WIDTH-2:0], 1'b0};
        carry_d = carry_q | bcd_adj[BCD_W-1];
        cnt_d   = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        hex_d   = carry_q ? {DIGITS{SEG_DASH}} : seg_all;
        ovf_d   = carry_q;
        done_d  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      refresh_q <= '0;
      shift_q   <= '0;
      bcd_q     <= '0;
      carry_q   <= 1'b0;
      cnt_q     <= '0;
      hex_q     <= {DIGITS{SEG_BLANK}};
      ovf_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      refresh_q <= refresh_q + 1'b1;
      shift_q   <= shift_d;
      bcd_q     <= bcd_d;
      carry_q   <= carry_d;
      cnt_q     <= cnt_d;
      hex_q     <= hex_d;
      ovf_q     <= ovf_d;
      done_q    <= done_d;
    end
  end

  assign hex      = hex_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign overflow = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_bcd_display_driver.sv
`default_nettype none
// ============================================================================
// tb_bcd_display_driver : randomized self-checking bench for
//   bcd_display_driver against an arithmetic decimal-display model.  Rev 1.0
// ============================================================================
module tb_bcd_display_driver;

  localparam int W  = 32;
  localparam int D  = 6;
  localparam int RB = 10;
  localparam int PERIOD_REF = 1 << RB;

  logic          clk = 1'b0;
  logic          rst;
  logic [W-1:0]  value;
  logic          update;
  logic [7*D-1:0] hex;
  logic          busy, done, overflow;

  logic [7:0]    value_t;
  logic [13:0]   hex_t;
  logic          busy_t, done_t, ovf_t;

  int n_tests = 0;
  int n_fail  = 0;
  int unsigned since_rel = 0;

  logic [6:0] seg_tab [0:9] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  bcd_display_driver #(.WIDTH(W), .DIGITS(D), .REFRESH_BITS(RB)) dut (
    .clk(clk), .rst(rst), .value(value), .update(update),
    .hex(hex), .busy(busy), .done(done), .overflow(overflow)
  );

  bcd_display_driver #(.WIDTH(8), .DIGITS(2), .REFRESH_BITS(4)) dut_t (
    .clk(clk), .rst(rst), .value(value_t), .update(1'b0),
    .hex(hex_t), .busy(busy_t), .done(done_t), .overflow(ovf_t)
  );

  always #5 clk = ~clk;

  // Index of the next rising edge, counted from the first edge after reset release.
  always @(posedge clk) begin
    if (!rst) since_rel <= 0;
    else      since_rel <= since_rel + 1;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1);
  end

  function automatic logic [55:0] exp_disp(input longint unsigned v, input int nd, output logic ov);
    logic [55:0] r;
    longint unsigned lim, pw;
    int d;
    lim = 1;
    for (int i = 0; i < nd; i++) lim = lim * 10;
    ov = (v >= lim);
    r  = {8{7'h7F}};
    pw = 1;
    for (int i = 0; i < nd; i++) begin
      d = int'((v / pw) % 10);
      if (ov) r[7*i +: 7] = 7'b0111111;
`ifdef LEADING_ZERO_BLANK_EN
      else if (i > 0 && v < pw) r[7*i +: 7] = 7'h7F;
`endif
      else r[7*i +: 7] = seg_tab[d];
      pw = pw * 10;
    end
    return r;
  endfunction

  task automatic wait_window();
    int guard = 0;
    while ((busy || (since_rel % PERIOD_REF) == 0 || (since_rel % PERIOD_REF) > 900) && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Drives one update request and collects observations up to the done cycle.
  task automatic run_conv(input logic [W-1:0] v, input bit no_wait, output int lat,
                          output logic [7*D-1:0] h, output logic ov, output int glitches,
                          output logic busy_at_done);
    logic [7*D-1:0] h0;
    if (!no_wait) wait_window();
    h0 = hex;
    value = v;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    lat = -1;
    glitches = 0;
    for (int k = 0; k < 100; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      if (!busy || hex !== h0) glitches++;
      @(negedge clk);
    end
    h = hex;
    ov = overflow;
    busy_at_done = busy;
  endtask

  task automatic test_reset();
    rst = 1'b0; update = 1'b0; value = '0; value_t = '0;
    repeat (3) @(negedge clk);
    n_tests++; if (hex !== {D{7'h7F}}) begin n_fail++; $display("FAIL reset_hex got=%h exp=%h", hex, {D{7'h7F}}); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got=%b exp=0", done); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
  endtask

  task automatic test_first_tick();
    logic [55:0] t; logic eo; int k;
    value = 32'd2024;
    rst = 1'b1;
    @(negedge clk);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL first_tick_busy got=%b exp=1", busy); end
    k = 0;
    while (!done && k < 100) begin @(negedge clk); k++; end
    t = exp_disp(64'(32'd2024), D, eo);
    n_tests++; if (k !== W + 1) begin n_fail++; $display("FAIL first_tick_latency got=%0d exp=%0d", k, W + 1); end
    n_tests++; if (hex !== t[7*D-1:0]) begin n_fail++; $display("FAIL first_tick_hex got=%h exp=%h", hex, t[7*D-1:0]); end
    n_tests++; if (overflow !== eo) begin n_fail++; $display("FAIL first_tick_overflow got=%b exp=%b", overflow, eo); end
  endtask

  task automatic test_directed();
    logic [W-1:0] vals [8] = '{32'd123456, 32'd42, 32'd0, 32'd1000000,
                              32'd999999, 32'd7, 32'd100000, 32'hFFFFFFFF};
    int lat, gl; logic [7*D-1:0] h; logic ov, bd, eo; logic [55:0] t;
    foreach (vals[i]) begin
      run_conv(vals[i], 1'b0, lat, h, ov, gl, bd);
      t = exp_disp(64'(vals[i]), D, eo);
      n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL directed_latency v=%0d got=%0d exp=%0d", vals[i], lat, W + 1); end
      n_tests++; if (gl !== 0) begin n_fail++; $display("FAIL directed_busy_hold v=%0d got=%0d exp=0", vals[i], gl); end
      n_tests++; if (bd !== 1'b0) begin n_fail++; $display("FAIL directed_busy_in_done v=%0d got=%b exp=0", vals[i], bd); end
      n_tests++; if (h !== t[7*D-1:0]) begin n_fail++; $display("FAIL directed_hex v=%0d got=%h exp=%h", vals[i], h, t[7*D-1:0]); end
      n_tests++; if (ov !== eo) begin n_fail++; $display("FAIL directed_overflow v=%0d got=%b exp=%b", vals[i], ov, eo); end
    end
  endtask

  task automatic test_random();
    int lat, gl; logic [7*D-1:0] h; logic ov, bd, eo; logic [55:0] t;
    logic [W-1:0] v; longint unsigned pw;
    for (int n = 0; n < 16; n++) begin
      case ($urandom_range(0, 3))
        0: v = $urandom();
        1: v = $urandom_range(0, 999999);
        2: begin
          pw = 1;
          repeat ($urandom_range(0, 6)) pw = pw * 10;
          v = W'(pw - longint'($urandom_range(0, 1)));
        end
        default: v = $urandom_range(0, 99);
      endcase
      run_conv(v, 1'b0, lat, h, ov, gl, bd);
      t = exp_disp(64'(v), D, eo);
      n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL random_latency v=%0d got=%0d exp=%0d", v, lat, W + 1); end
      n_tests++; if (h !== t[7*D-1:0]) begin n_fail++; $display("FAIL random_hex v=%0d got=%h exp=%h", v, h, t[7*D-1:0]); end
      n_tests++; if (ov !== eo) begin n_fail++; $display("FAIL random_overflow v=%0d got=%b exp=%b", v, ov, eo); end
    end
  endtask

  task automatic test_busy_ignore();
    logic [W-1:0] v1; int ndone, first_k; logic [7*D-1:0] hs; logic os, eo; logic [55:0] t;
    wait_window();
    v1 = $urandom_range(0, 999999);
    value = v1;
    update = 1'b1;
    @(negedge clk);
    ndone = 0; first_k = -1; hs = '0; os = 1'b0;
    for (int k = 0; k < 80; k++) begin
      if (done) begin
        ndone++;
        if (first_k < 0) begin first_k = k; hs = hex; os = overflow; end
      end
      if (k < 10)      update = 1'b1;
      else if (k < 25) update = 1'($urandom_range(0, 1));
      else             update = 1'b0;
      value = $urandom();
      @(negedge clk);
    end
    update = 1'b0;
    t = exp_disp(64'(v1), D, eo);
    n_tests++; if (ndone !== 1) begin n_fail++; $display("FAIL busy_ignore_done_count got=%0d exp=1", ndone); end
    n_tests++; if (first_k !== W + 1) begin n_fail++; $display("FAIL busy_ignore_latency got=%0d exp=%0d", first_k, W + 1); end
    n_tests++; if (hs !== t[7*D-1:0]) begin n_fail++; $display("FAIL busy_ignore_hex v=%0d got=%h exp=%h", v1, hs, t[7*D-1:0]); end
    n_tests++; if (os !== eo) begin n_fail++; $display("FAIL busy_ignore_overflow got=%b exp=%b", os, eo); end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, gl; logic [7*D-1:0] h; logic ov, bd, eo; logic [55:0] t;
    logic [W-1:0] v1, v2;
    v1 = $urandom_range(0, 999999);
    v2 = $urandom_range(0, 1999999);
    run_conv(v1, 1'b0, lat1, h, ov, gl, bd);
    run_conv(v2, 1'b1, lat2, h, ov, gl, bd);
    t = exp_disp(64'(v2), D, eo);
    n_tests++; if (lat1 !== W + 1) begin n_fail++; $display("FAIL b2b_first_latency got=%0d exp=%0d", lat1, W + 1); end
    n_tests++; if (lat2 !== W + 1) begin n_fail++; $display("FAIL b2b_second_latency got=%0d exp=%0d", lat2, W + 1); end
    n_tests++; if (gl !== 0) begin n_fail++; $display("FAIL b2b_accept_in_done got=%0d exp=0", gl); end
    n_tests++; if (h !== t[7*D-1:0]) begin n_fail++; $display("FAIL b2b_hex v=%0d got=%h exp=%h", v2, h, t[7*D-1:0]); end
    n_tests++; if (ov !== eo) begin n_fail++; $display("FAIL b2b_overflow got=%b exp=%b", ov, eo); end
  endtask

  task automatic test_reset_mid();
    int lat, gl, extra; logic [7*D-1:0] h; logic ov, bd, eo; logic [55:0] t;
    run_conv(32'd1000000, 1'b0, lat, h, ov, gl, bd);
    n_tests++; if (ov !== 1'b1) begin n_fail++; $display("FAIL reset_mid_pre_overflow got=%b exp=1", ov); end
    wait_window();
    value = 32'd654321;
    update = 1'b1;
    @(negedge clk);
    update = 1'b0;
    repeat (10) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (hex !== {D{7'h7F}}) begin n_fail++; $display("FAIL reset_mid_hex got=%h exp=%h", hex, {D{7'h7F}}); end
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_mid_busy got=%b exp=0", busy); end
    n_tests++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_mid_overflow got=%b exp=0", overflow); end
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done got=%b exp=0", done); end
    @(negedge clk);
    n_tests++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_mid_done_hold got=%b exp=0", done); end
    rst = 1'b1;
    run_conv(32'd777, 1'b1, lat, h, ov, gl, bd);
    t = exp_disp(64'(32'd777), D, eo);
    n_tests++; if (lat !== W + 1) begin n_fail++; $display("FAIL reset_release_latency got=%0d exp=%0d", lat, W + 1); end
    n_tests++; if (gl !== 0) begin n_fail++; $display("FAIL reset_release_busy_hold got=%0d exp=0", gl); end
    n_tests++; if (h !== t[7*D-1:0]) begin n_fail++; $display("FAIL reset_release_hex got=%h exp=%h", h, t[7*D-1:0]); end
    extra = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) extra++;
    end
    n_tests++; if (extra !== 0) begin n_fail++; $display("FAIL tick_update_single got=%0d extra dones exp=0", extra); end
  endtask

  task automatic test_tick_period();
    logic [7:0] cap; logic [55:0] t; logic eo;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    value_t = 8'($urandom_range(0, 255));
    cap = value_t;
    rst = 1'b1;
    for (int e = 0; e < 80; e++) begin
      @(negedge clk);
      n_tests++; if (done_t !== ((e % 16) == 9)) begin n_fail++; $display("FAIL tick_done edge=%0d got=%b exp=%b", e, done_t, (e % 16) == 9); end
      n_tests++; if (busy_t !== ((e % 16) <= 8)) begin n_fail++; $display("FAIL tick_busy edge=%0d got=%b exp=%b", e, busy_t, (e % 16) <= 8); end
      if ((e % 16) == 9) begin
        t = exp_disp(64'(cap), 2, eo);
        n_tests++; if (hex_t !== t[13:0]) begin n_fail++; $display("FAIL tick_hex v=%0d got=%h exp=%h", cap, hex_t, t[13:0]); end
        n_tests++; if (ovf_t !== eo) begin n_fail++; $display("FAIL tick_overflow v=%0d got=%b exp=%b", cap, ovf_t, eo); end
      end
      if (((e + 1) % 16) == 0) begin
        value_t = 8'($urandom_range(0, 255));
        cap = value_t;
      end else if (((e + 1) % 16) == 4) begin
        value_t = 8'($urandom_range(0, 255));
      end
    end
  endtask

  initial begin
    test_reset();
    test_first_tick();
    test_directed();
    test_random();
    test_busy_ignore();
    test_back_to_back();
    test_reset_mid();
    test_tick_period();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
